// File: rtl/div_pkg.sv
// Shared widths, FSM state type and the per-iteration approximation schedule
// for the sequential 16/8 restoring divider.
package div_pkg;

  localparam int unsigned DIV_W  = 8;
  localparam int unsigned DVD_W  = 16;
  localparam int unsigned N_ITER = 8;
  localparam int unsigned ITER_W = $clog2(N_ITER);
  localparam int unsigned LVL_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Number of approximate LSB cells in the row for a given iteration:
  // iterations 0 and 1 stay exact, then one more cell per iteration.
  function automatic logic [LVL_W-1:0] approx_level(input logic [ITER_W-1:0] iter,
                                                     input logic              en);
    if (!en || iter == '0) return '0;
    return LVL_W'(iter - ITER_W'(1));
  endfunction

endpackage

// File: rtl/div_row_cfg.sv
// One 9-bit subtract/restore row with a configurable number of approximate
// LSB cells.
//   x     : partial remainder with the next dividend bit shifted in
//   y     : divisor
//   level : cells k < level use the approximate borrow/difference equations
//   qs    : quotient bit (1 when the subtraction is kept)
//   rout  : restored or subtracted remainder
module div_row_cfg
  import div_pkg::*;
(
  input  logic [DIV_W:0]   x,
  input  logic [DIV_W-1:0] y,
  input  logic [LVL_W-1:0] level,
  output logic             qs,
  output logic [DIV_W-1:0] rout
);

  logic [DIV_W:0]   borrow;
  logic [DIV_W-1:0] diff;

  // Ripple-borrow chain; borrow-in of bit 0 is tied low.
  always_comb begin
    borrow = '0;
    diff   = '0;
    for (int k = 0; k < int'(DIV_W); k++) begin
      if (k < int'(level)) begin
        diff[k]     = (x[k] ^ y[k]) | borrow[k];
        borrow[k+1] = y[k] | (~x[k] & borrow[k]);
      end else begin
        diff[k]     = x[k] ^ y[k] ^ borrow[k];
        borrow[k+1] = (~x[k] & borrow[k]) | (~x[k] & y[k]) | (y[k] & borrow[k]);
      end
    end
    // x[8] set means x >= 256 > y, so the subtraction always fits.
    qs   = ~borrow[DIV_W] | x[DIV_W];
    rout = qs ? diff : x[DIV_W-1:0];
  end

endmodule

// File: rtl/app_div_seq.sv
// Sequential restoring 16/8 divider: one subtract/restore row reused for
// 8 iterations, with an optional approximate-LSB schedule.
//   clk, rst           : clock, synchronous active-high reset
//   start              : request, accepted in IDLE or DONE
//   dividend, divisor  : operands, captured on accept
//   approx_en          : 0 = exact, 1 = approximate schedule (captured)
//   busy               : high while iterating
//   done               : pulse when a result becomes valid
//   quotient/remainder : result, held until the next accept
//   div_err            : zero divisor or quotient overflow
module app_div_seq
  import div_pkg::*;
#(
  parameter bit APPROX_DEFAULT = 1'b1
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  input  logic             approx_en,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder,
  output logic             div_err
);

  div_state_t        state, state_n;
  logic              accept_c;
  logic              zero_div_c;
  logic [ITER_W-1:0] iter;
  logic [DIV_W-1:0]  rem_reg;
  logic [DIV_W-1:0]  shift_reg;
  logic [DIV_W-1:0]  divisor_q;
  logic              approx_q;
  logic              qs;
  logic [DIV_W-1:0]  rout;

  assign zero_div_c = (divisor == '0);

  div_row_cfg u_row (
    .x     ({rem_reg, shift_reg[DIV_W-1]}),
    .y     (divisor_q),
    .level (approx_level(iter, approx_q)),
    .qs    (qs),
    .rout  (rout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state; a zero divisor skips RUN entirely.
  always_comb begin
    state_n  = state;
    accept_c = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept_c = 1'b1;
          state_n  = zero_div_c ? DONE : RUN;
        end else if (state == DONE) begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (iter == ITER_W'(N_ITER - 1)) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_err   <= 1'b0;
      iter      <= '0;
      rem_reg   <= '0;
      shift_reg <= '0;
      divisor_q <= '0;
      approx_q  <= APPROX_DEFAULT;
    end else begin
      busy <= (state_n == RUN);
      done <= (state_n == DONE);
      if (accept_c) begin
        rem_reg   <= dividend[DVD_W-1:DIV_W];
        shift_reg <= dividend[DIV_W-1:0];
        iter      <= '0;
        divisor_q <= divisor;
        approx_q  <= approx_en;
        div_err   <= zero_div_c || (dividend[DVD_W-1:DIV_W] >= divisor);
        quotient  <= zero_div_c ? '1 : '0;
        remainder <= '0;
      end else if (state == RUN) begin
        rem_reg   <= rout;
        shift_reg <= {shift_reg[DIV_W-2:0], 1'b0};
        quotient  <= {quotient[DIV_W-2:0], qs};
        iter      <= iter + ITER_W'(1);
        if (iter == ITER_W'(N_ITER - 1)) remainder <= rout;
      end
    end
  end

endmodule

// File: tb/tb_app_div_seq.sv
// Directed bench for app_div_seq with hand-computed expected results.
module tb_app_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        approx_en;
  logic        busy;
  logic        done;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        div_err;

  int unsigned pass_cnt = 0;
  int unsigned fail_cnt = 0;
  int unsigned total_cnt = 0;
  int          edges;
  int          busy_cnt;
  int          done_cnt;

  app_div_seq #(.APPROX_DEFAULT(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .approx_en (approx_en),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_err   (div_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle at a negedge; operands are scrambled after accept.
  task automatic issue(input logic [15:0] dvd, input logic [7:0] dvs, input logic ap);
    dividend  = dvd;
    divisor   = dvs;
    approx_en = ap;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    dividend  = 16'($urandom);
    divisor   = 8'($urandom);
    approx_en = 1'($urandom);
  endtask

  // Edges after the accept edge until done is seen, bounded.
  task automatic wait_done(output int e, output int b);
    e = 0;
    b = 0;
    while (done !== 1'b1 && e < 20) begin
      if (busy === 1'b1) b++;
      @(negedge clk);
      e++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0; approx_en = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_quo",  16'(quotient), 16'd0);
    check("rst_rem",  16'(remainder), 16'd0);
    check("rst_err",  16'(div_err), 16'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1000 / 7 exact
    issue(16'd1000, 8'd7, 1'b0);
    check("e1000_busy0", 16'(busy), 16'd1);
    wait_done(edges, busy_cnt);
    check("e1000_lat",  16'(edges), 16'd8);
    check("e1000_busy", 16'(busy_cnt), 16'd8);
    check("e1000_quo",  16'(quotient), 16'd142);
    check("e1000_rem",  16'(remainder), 16'd6);
    check("e1000_err",  16'(div_err), 16'd0);
    @(negedge clk);
    check("idle_done", 16'(done), 16'd0);
    check("idle_busy", 16'(busy), 16'd0);
    check("idle_hold", 16'(quotient), 16'd142);

    // 0x4000 / 0x80 exact and approximate (no borrows below bit 7: identical)
    issue(16'h4000, 8'h80, 1'b0);
    wait_done(edges, busy_cnt);
    check("e4000_lat", 16'(edges), 16'd8);
    check("e4000_quo", 16'(quotient), 16'h80);
    check("e4000_rem", 16'(remainder), 16'h00);
    @(negedge clk);
    issue(16'h4000, 8'h80, 1'b1);
    wait_done(edges, busy_cnt);
    check("a4000_quo", 16'(quotient), 16'h80);
    check("a4000_rem", 16'(remainder), 16'h00);
    check("a4000_err", 16'(div_err), 16'd0);
    @(negedge clk);

    // 1000 / 7 approximate: iteration 5 diverges (12-7 yields 15)
    issue(16'd1000, 8'd7, 1'b1);
    wait_done(edges, busy_cnt);
    check("a1000_lat", 16'(edges), 16'd8);
    check("a1000_quo", 16'(quotient), 16'h8F);
    check("a1000_rem", 16'(remainder), 16'h3F);
    check("a1000_err", 16'(div_err), 16'd0);
    @(negedge clk);

    // zero divisor: done right after the accept edge, no RUN cycles
    issue(16'h1234, 8'h00, 1'b0);
    wait_done(edges, busy_cnt);
    check("z_lat",  16'(edges), 16'd0);
    check("z_busy", 16'(busy_cnt), 16'd0);
    check("z_quo",  16'(quotient), 16'hFF);
    check("z_rem",  16'(remainder), 16'h00);
    check("z_err",  16'(div_err), 16'd1);
    @(negedge clk);

    // overflow: 0x0900 / 9 runs normally, raw row result
    issue(16'h0900, 8'h09, 1'b0);
    wait_done(edges, busy_cnt);
    check("ov_lat", 16'(edges), 16'd8);
    check("ov_quo", 16'(quotient), 16'hFF);
    check("ov_rem", 16'(remainder), 16'h09);
    check("ov_err", 16'(div_err), 16'd1);
    @(negedge clk);

    // start mid-RUN ignored, start in DONE accepted
    issue(16'd1000, 8'd7, 1'b0);
    repeat (3) @(negedge clk);
    issue(16'h00FF, 8'h01, 1'b0);
    check("ign_busy", 16'(busy), 16'd1);
    wait_done(edges, busy_cnt);
    check("ign_lat", 16'(edges), 16'd4);
    check("ign_quo", 16'(quotient), 16'd142);
    check("ign_rem", 16'(remainder), 16'd6);
    issue(16'h00FF, 8'h01, 1'b0);
    check("b2b_done", 16'(done), 16'd0);
    check("b2b_busy", 16'(busy), 16'd1);
    check("b2b_qclr", 16'(quotient), 16'd0);
    check("b2b_rclr", 16'(remainder), 16'd0);
    wait_done(edges, busy_cnt);
    check("b2b_lat", 16'(edges), 16'd8);
    check("b2b_quo", 16'(quotient), 16'hFF);
    check("b2b_rem", 16'(remainder), 16'h00);
    check("b2b_err", 16'(div_err), 16'd0);
    @(negedge clk);

    // reset at iteration 4
    issue(16'd1000, 8'd7, 1'b1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy", 16'(busy), 16'd0);
    check("mrst_done", 16'(done), 16'd0);
    check("mrst_quo",  16'(quotient), 16'd0);
    check("mrst_rem",  16'(remainder), 16'd0);
    check("mrst_err",  16'(div_err), 16'd0);
    done_cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    check("mrst_nodone", 16'(done_cnt), 16'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
